serializer: RTL and testbench

- Parallel-to-serial converter; transmit-side counterpart of the team's 16-bit deserializer.
- Captures a parallel word plus a bit count, then shifts the bits out MSB-first, one per clock, with a per-bit valid strobe.
- Sits ahead of the serial link; its ser_data_o/ser_data_val_o pair drives the deserializer's data_i/data_val_i directly.

---
 rtl/serializer.sv | 77 +++++++
 tb/tb_serializer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serializer.sv
// Parallel-to-serial converter: captures a word and a bit count, then shifts
// the selected MSBs out one per clock with a per-bit valid strobe.
module serializer #(
  parameter  int WIDTH = 16,
  localparam int MOD_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [MOD_W-1:0] data_mod_i,
  input  logic             data_val_i,
  output logic             ser_data_o,
  output logic             ser_data_val_o,
  output logic             busy_o
);

  localparam logic [MOD_W:0] FULL_LEN = (MOD_W+1)'(WIDTH);
  localparam logic [MOD_W:0] MIN_LEN  = (MOD_W+1)'(3);
  localparam logic [MOD_W:0] LAST_CNT = (MOD_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [MOD_W:0]   cnt;
  logic [MOD_W:0]   len_in;
  logic             accept;

  // A zero bit count selects the full word.
  function automatic logic [MOD_W:0] eff_len(input logic [MOD_W-1:0] m);
    return (m == '0) ? FULL_LEN : {1'b0, m};
  endfunction

  assign len_in = eff_len(data_mod_i);
  assign accept = (state == IDLE) && data_val_i && (len_in >= MIN_LEN);

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST_CNT) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register and remaining-bit counter
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= data_i;
      cnt   <= len_in;
    end else if (state == SHIFT) begin
      shreg <= shreg << 1;
      cnt   <= cnt - LAST_CNT;
    end
  end

  // Outputs decode purely from registered state, so they fall with reset
  // immediately and never depend combinationally on the inputs.
  always_comb begin
    busy_o         = (state == SHIFT);
    ser_data_val_o = (state == SHIFT);
    ser_data_o     = (state == SHIFT) && shreg[WIDTH-1];
  end

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: vector tables, directed corner sequences, a randomized
// run against a transaction-level model, and a loopback through a modelled deserializer.
module tb_serializer;

  logic        clk = 1'b0;
  logic        srst;
  logic [15:0] data;
  logic [3:0]  mod;
  logic        dval;
  logic        ser;
  logic        sval;
  logic        busy;

  int total = 0;
  int bad   = 0;

  serializer #(.WIDTH(16)) dut (
    .clk_i          (clk),
    .srst_i         (srst),
    .data_i         (data),
    .data_mod_i     (mod),
    .data_val_i     (dval),
    .ser_data_o     (ser),
    .ser_data_val_o (sval),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  // Reference model: a word in flight plus the number of its bits still to come.
  int          m_rem  = 0;
  int          m_idx  = 0;
  logic [15:0] m_word = '0;

  // Loopback: sent words and a behavioural 16-bit deserializer.
  logic        lb_on = 1'b0;
  logic [15:0] sent_q[$];
  logic [15:0] des_sr;
  int          des_cnt = 0;
  int          n_acc   = 0;
  int          n_rcv   = 0;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  m;
    logic        v;
    logic        es;
    logic        ev;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [15:0] d, input logic [3:0] m, input logic v,
                              input logic es, input logic ev);
    vec_t r;
    r.d = d; r.m = m; r.v = v; r.es = es; r.ev = ev;
    tbl.push_back(r);
  endfunction

  function automatic logic exp_val();
    return m_rem > 0;
  endfunction

  function automatic logic exp_bit();
    return (m_rem > 0) ? m_word[15 - m_idx] : 1'b0;
  endfunction

  // Advance one clock: update the model from the pre-edge inputs, then sample #1 after.
  task automatic step();
    int mlen;
    mlen = (mod == 4'd0) ? 16 : int'(mod);
    if (m_rem > 0) begin
      m_idx++;
      m_rem--;
    end else if (dval && mlen >= 3) begin
      m_word = data;
      m_rem  = mlen;
      m_idx  = 0;
      if (lb_on) begin
        sent_q.push_back(data);
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
    if (lb_on && sval) begin
      des_sr = {des_sr[14:0], ser};
      des_cnt++;
      if (des_cnt == 16) begin
        des_cnt = 0;
        n_rcv++;
        if (sent_q.size() == 0) chk("loopback_extra_word", des_sr, 32'hdead);
        else chk("loopback_word", des_sr, sent_q.pop_front());
      end
    end
  endtask

  task automatic chk_all(input string name, input logic es, input logic ev);
    chk({name, "_ser"},  ser,  es);
    chk({name, "_val"},  sval, ev);
    chk({name, "_busy"}, busy, ev);
  endtask

  initial begin
    srst = 1'b1; data = '0; mod = '0; dval = 1'b0;
    #12;
    chk_all("reset", 1'b0, 1'b0);
    @(negedge clk);
    srst = 1'b0;
    m_rem = 0;

    // Partial word F000 / mod 5, then back-to-back 3-bit words with valid held high.
    add(16'hF000, 4'd5, 1'b1, 1'b1, 1'b1);
    add(16'h0000, 4'd0, 1'b0, 1'b1, 1'b1);
    add(16'h0000, 4'd0, 1'b0, 1'b1, 1'b1);
    add(16'h0000, 4'd0, 1'b0, 1'b1, 1'b1);
    add(16'h0000, 4'd0, 1'b0, 1'b0, 1'b1);
    add(16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
    add(16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
    add(16'h8000, 4'd3, 1'b1, 1'b1, 1'b1);
    add(16'h4000, 4'd3, 1'b1, 1'b0, 1'b1);
    add(16'h4000, 4'd3, 1'b1, 1'b0, 1'b1);
    add(16'h4000, 4'd3, 1'b1, 1'b0, 1'b0);
    add(16'h4000, 4'd3, 1'b1, 1'b0, 1'b1);
    add(16'h0000, 4'd0, 1'b0, 1'b1, 1'b1);
    add(16'h0000, 4'd0, 1'b0, 1'b0, 1'b1);
    add(16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < tbl.size(); i++) begin
      data = tbl[i].d; mod = tbl[i].m; dval = tbl[i].v;
      step();
      chk_all($sformatf("table%0d", i), tbl[i].es, tbl[i].ev);
    end
    dval = 1'b0;

    // Full word A5C3: 16 valid bits MSB-first, idle on cycle 17.
    data = 16'hA5C3; mod = 4'd0; dval = 1'b1;
    step();
    dval = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk_all($sformatf("full_bit%0d", k), 1'(16'hA5C3 >> (15 - k)), 1'b1);
      step();
    end
    chk_all("full_end", 1'b0, 1'b0);

    // Illegal lengths 1 and 2 are never accepted.
    data = 16'hFFFF; dval = 1'b1;
    for (int k = 0; k < 20; k++) begin
      mod = (k < 10) ? 4'd1 : 4'd2;
      step();
      chk_all($sformatf("illegal%0d", k), 1'b0, 1'b0);
    end
    dval = 1'b0;

    // A second word offered mid-transfer is dropped.
    data = 16'h0001; mod = 4'd0; dval = 1'b1;
    step();
    dval = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk_all($sformatf("busy_bit%0d", k), (k == 15), 1'b1);
      if (k == 4) begin data = 16'hFFFF; dval = 1'b1; end
      else dval = 1'b0;
      step();
    end
    for (int k = 0; k < 4; k++) begin
      chk_all($sformatf("busy_after%0d", k), 1'b0, 1'b0);
      step();
    end

    // Asynchronous reset at bit 7 of a full word.
    data = 16'hFFFF; mod = 4'd0; dval = 1'b1;
    step();
    dval = 1'b0;
    for (int k = 0; k < 7; k++) step();
    chk_all("pre_reset_bit7", 1'b1, 1'b1);
    #3 srst = 1'b1;
    #1;
    chk_all("async_reset", 1'b0, 1'b0);
    m_rem = 0;
    @(posedge clk);
    #2 srst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk_all($sformatf("post_reset%0d", k), 1'b0, 1'b0);
    end

    // Randomized traffic with random lengths against the model.
    for (int k = 0; k < 400; k++) begin
      dval = ($urandom_range(0, 3) != 0);
      data = 16'($urandom);
      mod  = 4'($urandom);
      step();
      chk_all($sformatf("rand%0d", k), exp_bit(), exp_val());
    end
    dval = 1'b0;
    for (int k = 0; k < 20; k++) step();

    // Loopback of 1000 full words into the deserializer model.
    sent_q.delete();
    des_cnt = 0;
    lb_on = 1'b1;
    for (int cyc = 0; cyc < 30000 && n_acc < 1000; cyc++) begin
      dval = ($urandom_range(0, 7) != 0);
      data = 16'($urandom);
      mod  = 4'd0;
      step();
    end
    dval = 1'b0;
    for (int k = 0; k < 20; k++) step();
    lb_on = 1'b0;
    chk("loopback_sent", n_acc, 1000);
    chk("loopback_rcvd", n_rcv, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
